// File: rtl/branch_predict_unit_pkg.sv
// branch_predict_unit_pkg: BTB geometry, counter encodings and counter update rule
package branch_predict_unit_pkg;
  localparam int BTB_ENTRIES = 16;
  localparam int IDX_W = 4;
  localparam int TAG_W = 26;
  localparam int TGT_W = 30;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_t;
  // Jumps pin the counter at strongly taken; a fresh branch allocation starts weak
  // in the resolved direction; a same-tag branch saturates up or down.
  function automatic ctr_t ctr_next(ctr_t c, logic hit, logic pdt, logic tk);
    return !pdt ? ST :
           !hit ? (tk ? WT : WNT) :
           tk   ? (c == ST  ? ST  : ctr_t'(c + 2'd1)) :
                  (c == SNT ? SNT : ctr_t'(c - 2'd1));
  endfunction
endpackage

// File: rtl/branch_predict_unit_if.sv
// branch_predict_unit_if: fetch lookup and ID resolve/update signals of the predictor
interface branch_predict_unit_if;
  logic [31:0] pc;
  logic [31:0] pre_npc;
  logic        wpcir;
  logic        flush;
  logic        pre_taken;
  logic        pre_bjpc_is_right;
  logic [31:0] id_pc;
  logic [31:0] id_target;
  logic        id_valid;
  logic        ud_BTB;
  logic        ud_pdt;
  logic        real_taken;
  modport master (
    output pc, wpcir, flush, id_pc, id_target, id_valid, ud_BTB, ud_pdt, real_taken,
    input  pre_npc, pre_taken, pre_bjpc_is_right
  );
  modport slave (
    input  pc, wpcir, flush, id_pc, id_target, id_valid, ud_BTB, ud_pdt, real_taken,
    output pre_npc, pre_taken, pre_bjpc_is_right
  );
endinterface

// File: rtl/branch_predict_unit_btb_entry_array.sv
// btb_entry_array: 16-entry direct-mapped BTB storage with one read port and one write port
module btb_entry_array
  import branch_predict_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_valid_o,
  output logic [TAG_W-1:0] rd_tag_o,
  output logic [TGT_W-1:0] rd_tgt_o,
  output ctr_t             rd_ctr_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic [TGT_W-1:0] wr_tgt_i,
  input  logic             wr_pdt_i,
  input  logic             wr_taken_i
);
  logic             valid_q [BTB_ENTRIES];
  logic [TAG_W-1:0] tag_q   [BTB_ENTRIES];
  logic [TGT_W-1:0] tgt_q   [BTB_ENTRIES];
  ctr_t             ctr_q   [BTB_ENTRIES];
  logic             wr_hit;
  ctr_t             ctr_d;
  // Read port returns the registered contents, so a same-cycle write is seen next cycle
  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_tgt_o   = tgt_q[rd_idx_i];
  assign rd_ctr_o   = ctr_q[rd_idx_i];
  assign wr_hit     = valid_q[wr_idx_i] && tag_q[wr_idx_i] == wr_tag_i;
  assign ctr_d      = ctr_next(ctr_q[wr_idx_i], wr_hit, wr_pdt_i, wr_taken_i);
  // Reset discards every entry; otherwise the write port allocates or refreshes one entry
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= WNT;
      end
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
      tag_q[wr_idx_i]   <= wr_tag_i;
      tgt_q[wr_idx_i]   <= wr_tgt_i;
      ctr_q[wr_idx_i]   <= ctr_d;
    end
  end
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: BTB-based next-PC predictor with ID-stage verification and update
module branch_predict_unit
  import branch_predict_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  branch_predict_unit_if.slave   bp
);
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [TGT_W-1:0] rd_tgt;
  ctr_t             rd_ctr;
  logic             hit, ptk, match, upd;
  logic             d_hit_q, d_hit_d, d_taken_q, d_taken_d;
  logic [TGT_W-1:0] d_target_q, d_target_d;

  btb_entry_array u_arr (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (bp.pc[5:2]),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_tgt_o   (rd_tgt),
    .rd_ctr_o   (rd_ctr),
    .wr_en_i    (upd),
    .wr_idx_i   (bp.id_pc[5:2]),
    .wr_tag_i   (bp.id_pc[31:6]),
    .wr_tgt_i   (bp.id_target[31:2]),
    .wr_pdt_i   (bp.ud_pdt),
    .wr_taken_i (bp.real_taken)
  );

  // Lookups are suppressed while in reset so the fetch path falls through to pc+4
  assign hit        = ~rst & rd_valid & (rd_tag == bp.pc[31:6]);
  assign ptk        = hit & rd_ctr[1];
  assign bp.pre_npc = ptk ? {rd_tgt, 2'b00} : bp.pc + 32'd4;
  assign upd        = ~rst & bp.id_valid & bp.wpcir & bp.ud_BTB;

  // ID-side capture: hold on stall, bubble on flush, else take the fetch-stage prediction
  always_comb begin
    d_hit_d    = !bp.wpcir ? d_hit_q    : bp.flush ? 1'b0 : hit;
    d_taken_d  = !bp.wpcir ? d_taken_q  : bp.flush ? 1'b0 : ptk;
    d_target_d = !bp.wpcir ? d_target_q : bp.flush ? '0   : rd_tgt;
  end

  // ID-side prediction registers
  always_ff @(posedge clk) begin
    if (rst) begin
      d_hit_q    <= 1'b0;
      d_taken_q  <= 1'b0;
      d_target_q <= '0;
    end else begin
      d_hit_q    <= d_hit_d;
      d_taken_q  <= d_taken_d;
      d_target_q <= d_target_d;
    end
  end

  assign bp.pre_taken         = d_taken_q;
  assign match                = d_hit_q & (d_target_q == bp.id_target[31:2]);
  assign bp.pre_bjpc_is_right = bp.ud_pdt ? (~d_taken_q | match) :
                                bp.ud_BTB ? (d_taken_q & match) : 1'b1;
endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL have pc  input  32  IF-stage fetch address.
REQ-004 SHALL have pre_npc  output  32  predicted next fetch address, combinational, to the PC mux.
REQ-005 SHALL have wpcir  input  1  IF/ID advance enable from the ID control unit; 0 = stall.
REQ-006 SHALL have flush  input  1  kill the instruction entering ID (refetch or exception cancel).
REQ-007 SHALL have pre_taken  output  1  registered prediction for the instruction now in ID.
REQ-008 SHALL have pre_bjpc_is_right  output  1  combinational: ID-stage predicted target is correct.
REQ-009 SHALL have id_pc  input  32  address of the instruction in ID.
REQ-010 SHALL have id_target  input  32  resolved branch/jump target computed in ID.
REQ-011 SHALL have id_valid, ud_BTB, ud_pdt, real_taken  inputs  1 each  ID instruction valid, BTB-update request, direction-update request (conditional branch), resolved direction.

Function
REQ-012 SHALL hold 16 direct-mapped entries: valid (1), tag = pc[31:6] (26), target[31:2] (30), 2-bit saturating counter.
REQ-013 Lookup: index = pc[5:2]; hit = valid & tag match; predict taken = hit & counter[1].
REQ-014 pre_npc SHALL be {target,2'b00} when predict taken, else pc+4 (32-bit wrap, 0xFFFFFFFC+4 = 0).
REQ-015 On wpcir=1 and flush=0, SHALL register hit, predict-taken and target into ID-side registers; on wpcir=0 SHALL hold them.
REQ-016 On flush=1 with wpcir=1, ID-side registers SHALL load hit=0, taken=0, target=0; flush with wpcir=0 SHALL have no effect.
REQ-017 pre_taken SHALL equal the ID-side registered taken bit.
REQ-018 Target match = d_hit & (d_target == id_target[31:2]).
REQ-019 pre_bjpc_is_right SHALL be (~pre_taken | match) when ud_pdt=1, (pre_taken & match) when ud_BTB=1 and ud_pdt=0, and 1 otherwise.
REQ-020 Update fires when id_valid & wpcir & ud_BTB; index = id_pc[5:2].
REQ-021 On update: valid←1, tag←id_pc[31:6], target←id_target[31:2].
REQ-022 Counter on update, entry hit with same tag and ud_pdt=1: increment if real_taken, else decrement; saturate at 00 and 11.
REQ-023 Counter on allocation (miss or tag differs) with ud_pdt=1: 10 if real_taken, else 01.
REQ-024 Counter when ud_pdt=0 (jump): 11.
REQ-025 Same-cycle lookup and update of one index: lookup SHALL see pre-update contents; new contents visible the next cycle.
REQ-026 Updates SHALL not depend on flush; the ID instruction resolves before flush takes effect.

Reset
REQ-027 rst SHALL clear all valid bits, set all counters to 01, and clear the ID-side hit, taken and target registers.
REQ-028 While rst=1, pre_taken=0 and no update SHALL occur; pre_npc = pc+4 during and after reset until the first allocation.
REQ-029 rst asserted mid-operation SHALL discard every entry in the same edge; no partial state is retained.

Structure
REQ-030 A shared package SHALL hold BTB_ENTRIES=16, IDX_W=4, TAG_W=26, TGT_W=30, and counter encodings SNT=00, WNT=01, WT=10, ST=11.
REQ-031 Entry storage plus update logic SHALL be one sub-module, btb_entry_array (one read port, one write port); lookup muxing, ID registers and the compare stay in the top.

Verification
REQ-032 After reset, pc=0x00400010 -> pre_npc=0x00400014, pre_taken=0 next cycle.
REQ-033 Taken beq at id_pc=0x00400020, id_target=0x00400100, real_taken=1 -> entry 8 counter 10; next fetch of 0x00400020 -> pre_npc=0x00400100, pre_taken=1 in ID, pre_bjpc_is_right=1.
REQ-034 Same branch not taken twice -> counter 10→01→00; fetch -> pre_npc=0x00400024.
REQ-035 Jump at 0x00400030 (ud_BTB=1, ud_pdt=0), first pass -> pre_bjpc_is_right=0 and entry written with counter 11; second pass, id_target changed to 0x00400200 -> pre_bjpc_is_right=0 and target rewritten.
REQ-036 Aliasing pc 0x00400020 vs 0x00401020 -> second lookup misses and then allocates; stall (wpcir=0) -> ID registers hold; flush with wpcir=1 -> pre_taken=0.
REQ-037 Same-index update and lookup in one cycle -> old prediction that cycle, new one the next; rst asserted mid-run -> all lookups miss.
